// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta DAC sample path (feeder, FIFO, modulator wrapper).
package sdm_pkg;

  localparam int SDM_DW       = 16;
  localparam int SDM_OSR_LOG2 = 6;
  localparam int SDM_FIFO_AW  = 3;

  typedef logic signed [SDM_DW-1:0] sample_t;

endpackage

// File: rtl/sdm_sample_fifo.sv
// Synchronous sample FIFO, depth 2^AW, with occupancy output and a look-ahead head word.
module sdm_sample_fifo
  import sdm_pkg::*;
#(
  parameter int DW = SDM_DW,
  parameter int AW = SDM_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_wr, do_rd;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  always_comb begin
    do_wr    = wr_valid && (level_q != FULL_LVL);
    do_rd    = rd_en && (level_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign wr_ready = (level_q != FULL_LVL);

endmodule

// File: rtl/sdm_interp_feeder.sv
// Releases one buffered sample per 2^OSR_LOG2-clock frame and drives the modulator
// input as a zero-order hold or a linear ramp between consecutive samples.
module sdm_interp_feeder
  import sdm_pkg::*;
#(
  parameter int DW       = SDM_DW,
  parameter int OSR_LOG2 = SDM_OSR_LOG2,
  parameter int FIFO_AW  = SDM_FIFO_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               lin_mode,
  input  logic               wr_valid,
  input  logic [DW-1:0]      wr_data,
  output logic               wr_ready,
  output logic [FIFO_AW:0]   level,
  input  logic               underrun_clr,
  output logic               underrun,
  output logic               frame_tick,
  output logic [DW-1:0]      dout
);

  localparam int ACC_W = DW + OSR_LOG2;

  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic [DW-1:0]       nxt_q, nxt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DW:0]         step_q, step_d;
  logic                underrun_q, underrun_d;
  logic                boundary, pop, fifo_empty;
  logic [DW-1:0]       head;

  sdm_sample_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (pop),
    .rd_data  (head),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign boundary = en && (phase_q == '1);
  assign pop      = boundary && !fifo_empty;

  // The frame-start value (cur) is the acc reload value itself, so acc carries it
  // for the whole frame; step is the full-precision difference toward the next sample.
  always_comb begin
    phase_d    = phase_q;
    nxt_d      = nxt_q;
    acc_d      = acc_q;
    step_d     = step_q;
    underrun_d = underrun_q;
    if (underrun_clr) underrun_d = 1'b0;
    if (boundary) begin
      phase_d = '0;
      acc_d   = {nxt_q, {OSR_LOG2{1'b0}}};
      step_d  = '0;
      if (pop) begin
        nxt_d = head;
        if (lin_mode) step_d = {head[DW-1], head} - {nxt_q[DW-1], nxt_q};
      end else begin
        underrun_d = 1'b1;
      end
    end else if (en) begin
      phase_d = phase_q + 1'b1;
      acc_d   = acc_q + {{(OSR_LOG2-1){step_q[DW]}}, step_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      nxt_q      <= '0;
      acc_q      <= '0;
      step_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      nxt_q      <= nxt_d;
      acc_q      <= acc_d;
      step_q     <= step_d;
      underrun_q <= underrun_d;
    end
  end

  assign frame_tick = boundary;
  assign underrun   = underrun_q;
  assign dout       = acc_q[ACC_W-1:OSR_LOG2];

endmodule

// File: tb/tb_sdm_interp_feeder.sv
// Directed bench for sdm_interp_feeder with 4-clock frames: reset, hold, ramps, full FIFO, underrun.
module tb_sdm_interp_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        lin_mode = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [3:0]  level;
  logic        underrun_clr = 1'b0;
  logic        underrun;
  logic        frame_tick;
  logic [15:0] dout;

  int tests = 0;
  int fails = 0;

  logic [15:0] lin_exp [20] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0100, 16'h0200, 16'h0300,
    16'h0400, 16'h0340, 16'h0280, 16'h01C0,
    16'h0100, 16'h0080, 16'h0000, 16'hFF80,
    16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00
  };

  sdm_interp_feeder #(.DW(16), .OSR_LOG2(2), .FIFO_AW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .lin_mode     (lin_mode),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .level        (level),
    .underrun_clr (underrun_clr),
    .underrun     (underrun),
    .frame_tick   (frame_tick),
    .dout         (dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    $display("[TB] write 0x%04h -> level %0d wr_ready %0b", d, level, wr_ready);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_dout", dout, 16'h0000);
    check("rst_level", level, 4'd0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_underrun", underrun, 1'b0);
    check("rst_frame_tick", frame_tick, 1'b0);

    // Hold mode: two frames of zero while the samples move through nxt, then each held 4 cycles.
    write(16'h1000);
    write(16'h2000);
    check("hold_level2", level, 4'd2);
    en = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) tick();
      $display("[TB] hold c=%0d dout=0x%04h tick=%0b", c, dout, frame_tick);
      check($sformatf("hold_dout_c%0d", c), dout,
            (c < 8) ? 16'h0000 : ((c < 12) ? 16'h1000 : 16'h2000));
      check($sformatf("hold_tick_c%0d", c), frame_tick, (c % 4) == 3);
    end
    check("hold_underrun", underrun, 1'b1);
    check("hold_level0", level, 4'd0);
    en = 1'b0;

    // Asynchronous reset mid-cycle with nonzero dout, level and underrun.
    write(16'h3000);
    check("pre_rst_level", level, 4'd1);
    #3;
    rst = 1'b1;
    #1;
    $display("[TB] async reset dout=0x%04h level=%0d", dout, level);
    check("arst_dout", dout, 16'h0000);
    check("arst_level", level, 4'd0);
    check("arst_wr_ready", wr_ready, 1'b1);
    check("arst_underrun", underrun, 1'b0);
    tick();
    rst = 1'b0;

    // Linear mode: 0 -> 0x0400 -> 0x0100 -> 0xFF00, then underrun holds flat.
    lin_mode = 1'b1;
    write(16'h0400);
    write(16'h0100);
    write(16'hFF00);
    en = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      $display("[TB] lin c=%0d dout=0x%04h underrun=%0b", c, dout, underrun);
      check($sformatf("lin_dout_c%0d", c), dout, lin_exp[c]);
      check($sformatf("lin_underrun_c%0d", c), underrun, c >= 16);
    end

    // Clear coinciding with another empty boundary: set wins.
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    $display("[TB] clr at empty boundary underrun=%0b", underrun);
    check("clr_vs_set_underrun", underrun, 1'b1);
    check("clr_vs_set_dout", dout, 16'hFF00);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    $display("[TB] clr pulse underrun=%0b", underrun);
    check("clr_underrun", underrun, 1'b0);
    en = 1'b0;

    // Full FIFO: 9th write dropped, write refused on a popping boundary.
    lin_mode = 1'b0;
    for (int i = 1; i <= 8; i++) write(16'(i * 16'h1111));
    check("full_level", level, 4'd8);
    check("full_wr_ready", wr_ready, 1'b0);
    write(16'hDEAD);
    check("full_drop_level", level, 4'd8);
    en = 1'b1;
    tick();
    tick();
    check("full_pre_tick", frame_tick, 1'b1);
    wr_valid = 1'b1;
    wr_data  = 16'hDEAD;
    tick();
    wr_valid = 1'b0;
    $display("[TB] write+pop while full level=%0d", level);
    check("full_pop_level", level, 4'd7);
    check("full_pop_wr_ready", wr_ready, 1'b1);
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) repeat (4) tick();
      $display("[TB] drain frame %0d dout=0x%04h", j, dout);
      check($sformatf("drain_dout_f%0d", j), dout, (j == 0) ? 16'hFF00 : 16'(j * 16'h1111));
      check($sformatf("drain_underrun_f%0d", j), underrun, j == 8);
    end
    check("drain_level", level, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
